// File: rtl/ascon_axil_master.sv
// Single-outstanding AXI4-Lite master bridging a simple cmd/rsp handshake.
// Optional watchdog abort enabled with `define ASCON_AXIL_TIMEOUT_EN.
module ascon_axil_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_resp_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

  state_t      state_q, state_d;
  logic        aw_done_q, w_done_q;
  logic        aw_hs, w_hs, abort, active;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [1:0]  resp_q;

  assign active = (state_q == WRITE) || (state_q == WRESP) ||
                  (state_q == READ)  || (state_q == RDATA);

`ifdef ASCON_AXIL_TIMEOUT_EN
  logic [31:0] timer_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else if (cmd_valid_i && cmd_ready_o) begin
      timer_q <= '0;
    end else if (active) begin
      timer_q <= timer_q + 32'd1;
    end
  end

  // Abort cycle itself drives no AXI valid/ready, so no handshake can race it.
  assign abort = active && (timer_q == TIMEOUT_CYCLES);
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign abort          = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    bready_o    = 1'b0;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = rst_ni;
        if (cmd_valid_i && rst_ni) state_d = cmd_write_i ? WRITE : READ;
      end
      WRITE: begin
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        if ((aw_done_q || awready_i) && (w_done_q || wready_i)) state_d = WRESP;
      end
      WRESP: begin
        bready_o = 1'b1;
        if (bvalid_i) state_d = RESP;
      end
      READ: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = RDATA;
      end
      RDATA: begin
        rready_o = 1'b1;
        if (rvalid_i) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      awvalid_o = 1'b0;
      wvalid_o  = 1'b0;
      bready_o  = 1'b0;
      arvalid_o = 1'b0;
      rready_o  = 1'b0;
      state_d   = RESP;
    end
  end

  assign aw_hs = awvalid_o && awready_i;
  assign w_hs  = wvalid_o && wready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      if (cmd_valid_i && cmd_ready_o) begin
        addr_q    <= cmd_addr_i;
        wdata_q   <= cmd_wdata_i;
        be_q      <= cmd_be_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if (abort) begin
        rdata_q <= '0;
        resp_q  <= 2'b10;
      end else if (bready_o && bvalid_i) begin
        rdata_q <= '0;
        resp_q  <= bresp_i;
      end else if (rready_o && rvalid_i) begin
        rdata_q <= rdata_i;
        resp_q  <= rresp_i;
      end
    end
  end

  assign awaddr_o    = addr_q;
  assign araddr_o    = addr_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = be_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_resp_o  = resp_q;

endmodule

// File: tb/tb_ascon_axil_master.sv
// Directed self-checking bench for ascon_axil_master (TIMEOUT_CYCLES=16).
module tb_ascon_axil_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
  logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
  logic [3:0]  cmd_be_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic        awvalid_o, awready_i = 1'b0;
  logic [31:0] awaddr_o;
  logic        wvalid_o, wready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        bvalid_i = 1'b0, bready_o;
  logic [1:0]  bresp_i = '0;
  logic        arvalid_o, arready_i = 1'b0;
  logic [31:0] araddr_o;
  logic        rvalid_i = 1'b0, rready_o;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp_i = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ascon_axil_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_resp_o(rsp_resp_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i)
  );

  // Advance one clock; sample/drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    step();
    checks++;
    if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready_o); end
    checks++;
    if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes got %b exp 000000",
                         {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o});
    end
    checks++;
    if ({awaddr_o, wdata_o, wstrb_o, rsp_rdata_o, rsp_resp_o} !== 102'b0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {awaddr_o, wdata_o, wstrb_o, rsp_rdata_o, rsp_resp_o});
    end
    rst_ni = 1'b1;
    step();
    checks++;
    if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready got %b exp 1", cmd_ready_o); end
  endtask

  task automatic test_write();
    int aw_cnt = 0;
    int w_cnt = 0;
    bit done = 1'b0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h5;
    cmd_wdata_i = 32'hDEADBEEF; cmd_be_i = 4'hF;
    wready_i = 1'b1; awready_i = 1'b0;
    step();
    cmd_valid_i = 1'b0; cmd_wdata_i = '0; cmd_addr_i = '0; cmd_be_i = '0;
    checks++;
    if ({awaddr_o, wdata_o, wstrb_o} !== {32'h5, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL write_regs got %h %h %h exp 00000005 deadbeef f", awaddr_o, wdata_o, wstrb_o);
    end
    for (int i = 0; i < 20; i++) begin
      if (awvalid_o) aw_cnt++;
      if (wvalid_o) w_cnt++;
      awready_i = awvalid_o && (aw_cnt == 3);
      bvalid_i  = bready_o;
      bresp_i   = 2'b00;
      if (rsp_valid_o) begin done = 1'b1; break; end
      step();
    end
    wready_i = 1'b0; awready_i = 1'b0; bvalid_i = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL write_timeout got %b exp 1", done); end
    checks++;
    if (aw_cnt != 3) begin errors++; $display("FAIL write_awvalid_cycles got %0d exp 3", aw_cnt); end
    checks++;
    if (w_cnt != 1) begin errors++; $display("FAIL write_wvalid_cycles got %0d exp 1", w_cnt); end
    checks++;
    if ({rsp_resp_o, rsp_rdata_o} !== 34'b0) begin
      errors++; $display("FAIL write_rsp got %b %h exp 00 00000000", rsp_resp_o, rsp_rdata_o);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    checks++;
    if ({cmd_ready_o, rsp_valid_o} !== 2'b10) begin
      errors++; $display("FAIL write_return_idle got %b exp 10", {cmd_ready_o, rsp_valid_o});
    end
  endtask

  task automatic test_read_latency();
    int lat = 1;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h6;
    arready_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'h12345678; rresp_i = 2'b00;
    step();
    cmd_valid_i = 1'b0; cmd_addr_i = '0;
    checks++;
    if ({arvalid_o, araddr_o} !== {1'b1, 32'h6}) begin
      errors++; $display("FAIL read_ar got %b %h exp 1 00000006", arvalid_o, araddr_o);
    end
    while (!rsp_valid_o && lat < 20) begin
      step();
      lat++;
      if (lat == 2) begin
        checks++;
        if (rready_o !== 1'b1) begin errors++; $display("FAIL read_rready_n2 got %b exp 1", rready_o); end
      end
    end
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    checks++;
    if (lat != 3) begin errors++; $display("FAIL read_latency got %0d exp 3", lat); end
    checks++;
    if ({rsp_valid_o, rsp_resp_o, rsp_rdata_o} !== {1'b1, 2'b00, 32'h12345678}) begin
      errors++; $display("FAIL read_rsp got %b %b %h exp 1 00 12345678", rsp_valid_o, rsp_resp_o, rsp_rdata_o);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_resp_backpressure();
    int lat = 0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h40;
    arready_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'hA5A50F0F; rresp_i = 2'b01;
    step();
    cmd_valid_i = 1'b0;
    while (!rsp_valid_o && lat < 20) begin step(); lat++; end
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = '0;
    // Offer a competing command while the response is stalled.
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h99;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rsp_valid_o, rsp_resp_o, rsp_rdata_o} !== {1'b1, 2'b01, 32'hA5A50F0F}) begin
        errors++; $display("FAIL stall_rsp[%0d] got %b %b %h exp 1 01 a5a50f0f", i, rsp_valid_o, rsp_resp_o, rsp_rdata_o);
      end
      checks++;
      if ({cmd_ready_o, awvalid_o, arvalid_o} !== 3'b000) begin
        errors++; $display("FAIL stall_cmd[%0d] got %b exp 000", i, {cmd_ready_o, awvalid_o, arvalid_o});
      end
      step();
    end
    cmd_valid_i = 1'b0; cmd_addr_i = '0;
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    checks++;
    if ({cmd_ready_o, rsp_valid_o, awvalid_o} !== 3'b100) begin
      errors++; $display("FAIL stall_release got %b exp 100", {cmd_ready_o, rsp_valid_o, awvalid_o});
    end
  endtask

  task automatic test_timeout();
    int busy = 0;
    bit done = 1'b0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h80;
    cmd_wdata_i = 32'h1; cmd_be_i = 4'h1;
    awready_i = 1'b1; wready_i = 1'b1; bvalid_i = 1'b0;
    step();
    cmd_valid_i = 1'b0;
`ifdef ASCON_AXIL_TIMEOUT_EN
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid_o) begin done = 1'b1; break; end
      if (awvalid_o || wvalid_o || bready_o || arvalid_o || rready_o) busy++;
      step();
    end
    awready_i = 1'b0; wready_i = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL timeout_abort got %b exp 1", done); end
    checks++;
    if (busy != 16) begin errors++; $display("FAIL timeout_cycles got %0d exp 16", busy); end
    checks++;
    if ({rsp_resp_o, rsp_rdata_o} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL timeout_rsp got %b %h exp 10 00000000", rsp_resp_o, rsp_rdata_o);
    end
`else
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid_o) done = 1'b1;
      step();
    end
    awready_i = 1'b0; wready_i = 1'b0;
    checks++;
    if ({done, bready_o} !== 2'b01) begin
      errors++; $display("FAIL no_timeout_wait got %b exp 01", {done, bready_o});
    end
    bvalid_i = 1'b1; bresp_i = 2'b11;
    step();
    bvalid_i = 1'b0; bresp_i = '0;
    checks++;
    if ({rsp_valid_o, rsp_resp_o, rsp_rdata_o} !== {1'b1, 2'b11, 32'h0}) begin
      errors++; $display("FAIL late_bresp got %b %b %h exp 1 11 00000000", rsp_valid_o, rsp_resp_o, rsp_rdata_o);
    end
`endif
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    checks++;
    if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL timeout_idle got %b exp 1", cmd_ready_o); end
  endtask

  task automatic test_reset_inflight();
    bit seen = 1'b0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'hC0;
    arready_i = 1'b1; rvalid_i = 1'b0;
    step();
    cmd_valid_i = 1'b0; cmd_addr_i = '0;
    step();
    arready_i = 1'b0;
    checks++;
    if (rready_o !== 1'b1) begin errors++; $display("FAIL inflight_rdata got %b exp 1", rready_o); end
    rst_ni = 1'b0;
    step();
    checks++;
    if ({cmd_ready_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o} !== 7'b0) begin
      errors++; $display("FAIL inflight_reset_ctrl got %b exp 0000000",
                         {cmd_ready_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o});
    end
    checks++;
    if ({araddr_o, wdata_o, wstrb_o, rsp_rdata_o, rsp_resp_o} !== 102'b0) begin
      errors++; $display("FAIL inflight_reset_data got %h exp 0", {araddr_o, wdata_o, wstrb_o, rsp_rdata_o, rsp_resp_o});
    end
    rst_ni = 1'b1;
    rvalid_i = 1'b1; rdata_i = 32'hBAD0BAD0;
    step();
    checks++;
    if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL inflight_idle got %b exp 1", cmd_ready_o); end
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid_o || rready_o) seen = 1'b1;
      step();
    end
    rvalid_i = 1'b0; rdata_i = '0;
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL inflight_no_rsp got %b exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_latency();
    test_resp_backpressure();
    test_timeout();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/ascon_axil_master.md
ASCON_AXIL_MASTER -- requirements
Module: ascon_axil_master

Interface
REQ-001 SHALL have one parameter: TIMEOUT_CYCLES, default 256, cycles a transaction may wait before abort (used only with ASCON_AXIL_TIMEOUT_EN).
REQ-002 SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk_i  in  1  clock, all logic on rising edge.
REQ-004 rst_ni  in  1  synchronous active-low reset.
REQ-005 cmd_valid_i  in  1  command request.
REQ-006 cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-007 cmd_write_i  in  1  1 = write, 0 = read.
REQ-008 cmd_addr_i  in  32  target address.
REQ-009 cmd_wdata_i  in  32  write data.
REQ-010 cmd_be_i  in  4  write byte enables.
REQ-011 rsp_valid_o  out  1  response available.
REQ-012 rsp_ready_i  in  1  response consumed.
REQ-013 rsp_rdata_o  out  32  read data, 0 for writes.
REQ-014 rsp_resp_o  out  2  captured BRESP/RRESP or abort code.
REQ-015 awvalid_o  out  1  write-address valid.
REQ-016 awready_i  in  1  write-address ready.
REQ-017 awaddr_o  out  32  write address.
REQ-018 wvalid_o  out  1  write-data valid.
REQ-019 wready_i  in  1  write-data ready.
REQ-020 wdata_o  out  32  write data.
REQ-021 wstrb_o  out  4  write strobes.
REQ-022 bvalid_i  in  1  write response valid.
REQ-023 bready_o  out  1  write response ready.
REQ-024 bresp_i  in  2  write response code.
REQ-025 arvalid_o  out  1  read-address valid.
REQ-026 arready_i  in  1  read-address ready.
REQ-027 araddr_o  out  32  read address.
REQ-028 rvalid_i  in  1  read data valid.
REQ-029 rready_o  out  1  read data ready.
REQ-030 rdata_i  in  32  read data.
REQ-031 rresp_i  in  2  read response code.

Function
REQ-032 FSM states IDLE, WRITE, WRESP, READ, RDATA, RESP; exactly one outstanding transaction; cmd_ready_o high only in IDLE.
REQ-033 IDLE: on cmd_valid_i, register write/addr/wdata/be; next state WRITE if cmd_write_i else READ; awaddr_o/araddr_o/wdata_o/wstrb_o driven from these registers, stable until RESP.
REQ-034 WRITE: awvalid_o and wvalid_o both asserted on entry; each drops independently the cycle after its own handshake; go WRESP once both handshakes done (same or different cycles).
REQ-035 WRESP: bready_o=1; on bvalid_i capture bresp_i, rdata register=0, go RESP.
REQ-036 READ: arvalid_o=1 until arready_i, then RDATA; RDATA: rready_o=1; on rvalid_i capture rdata_i and rresp_i, go RESP.
REQ-037 RESP: rsp_valid_o=1, rsp_rdata_o/rsp_resp_o held stable until rsp_ready_i, then IDLE; new command accepted no earlier than the following cycle.
REQ-038 A valid output, once raised, SHALL NOT drop before its handshake (except timeout abort).
REQ-039 Minimum latency, zero-wait slave: command accept cycle N, address/data valid N+1, B/R ready N+2, rsp_valid_o N+3.

Reset
REQ-040 rst_ni low at clock edge: state IDLE, all valid/ready outputs 0 (cmd_ready_o 0 while rst_ni low), all data outputs 0; in-flight transaction abandoned without response.

Configuration
REQ-041 With ASCON_AXIL_TIMEOUT_EN defined: counter clears on command accept, increments in WRITE/WRESP/READ/RDATA; when it reaches TIMEOUT_CYCLES, drop all AXI valid/ready, go RESP with rsp_resp_o=2'b10, rsp_rdata_o=0.
REQ-042 Without ASCON_AXIL_TIMEOUT_EN: no counter; transactions wait indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-043 Write addr 0x5, data 0xDEADBEEF, be 0xF; wready immediate, awready after 2 cycles -> wvalid_o 1 cycle, awvalid_o 3 cycles, bresp 00 -> rsp_resp_o 00, rsp_rdata_o 0.
REQ-044 Read addr 0x6, zero-wait slave returns 0x12345678/00 -> rsp_valid_o exactly 3 cycles after accept with rsp_rdata_o 0x12345678.
REQ-045 rsp_ready_i low 4 cycles during RESP -> outputs stable, cmd_ready_o 0, cmd_valid_i ignored until release.
REQ-046 Timeout enabled, TIMEOUT_CYCLES=16, bvalid_i never asserted -> abort after 16 cycles, rsp_resp_o 2'b10.
REQ-047 rst_ni low during RDATA -> next cycle all outputs 0; after release IDLE, no rsp_valid_o for abandoned read.
